// File: rtl/axi_ram_slave.sv
// AXI4 slave backed by a byte-enabled single-clock dual-port RAM; independent write and read engines.
// Define AXI_RAM_WRAP_EN to honour WRAP bursts; otherwise WRAP is handled as INCR.
module axi_ram_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_W      = $clog2(STRB_WIDTH);
  localparam int IDX_W      = ADDR_WIDTH - OFF_W;
  localparam int DEPTH      = 2 ** IDX_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wrState_e;
  typedef enum logic {R_IDLE, R_DATA} rdState_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  wrState_e              wrState_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [IDX_W-1:0]      wrIdx_q, wrIdx_d, wrMask_q;
  logic [7:0]            wrLen_q, wrCnt_q;
  logic                  wrEn;

  rdState_e              rdState_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [IDX_W-1:0]      rdIdx_q, rdIdx_d, rdMask_q;
  logic [7:0]            rdLen_q, rdCnt_q;

  logic                  unusedAddrBits;

  // Mask of index bits allowed to advance: none for FIXED, all for INCR, low bits for WRAP.
  function automatic logic [IDX_W-1:0] burstMask(input logic [1:0] burst, input logic [7:0] len);
    burstMask = '1;
    if (burst == 2'b00) begin
      burstMask = '0;
    end
`ifdef AXI_RAM_WRAP_EN
    else if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      burstMask = IDX_W'(len);
    end
`else
    if (len == 8'hFF) burstMask = '1;
`endif
  endfunction

  function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx, input logic [IDX_W-1:0] mask);
    nextIdx = (idx & ~mask) | ((idx + 1'b1) & mask);
  endfunction

  assign wrIdx_d        = nextIdx(wrIdx_q, wrMask_q);
  assign rdIdx_d        = nextIdx(rdIdx_q, rdMask_q);
  assign wrEn           = wready_q && s_axi_wvalid && !rst;
  assign unusedAddrBits = ^{s_axi_awaddr, s_axi_araddr};

  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) mem[wrIdx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrState_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      wrIdx_q   <= '0;
      wrMask_q  <= '0;
      wrLen_q   <= '0;
      wrCnt_q   <= '0;
    end else begin
      case (wrState_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awready_q && s_axi_awvalid) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= s_axi_awid;
            wrIdx_q   <= s_axi_awaddr[ADDR_WIDTH-1:OFF_W];
            wrMask_q  <= burstMask(s_axi_awburst, s_axi_awlen);
            wrLen_q   <= s_axi_awlen;
            wrCnt_q   <= '0;
            wrState_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (wrEn) begin
            wrIdx_q <= wrIdx_d;
            wrCnt_q <= wrCnt_q + 8'd1;
            if (wrCnt_q == wrLen_q) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              wrState_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wrState_q <= W_IDLE;
          end
        end
        default: wrState_q <= W_IDLE;
      endcase
    end
  end

  // The next beat is fetched on the same edge that accepts the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdState_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rdIdx_q   <= '0;
      rdMask_q  <= '0;
      rdLen_q   <= '0;
      rdCnt_q   <= '0;
    end else begin
      case (rdState_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arready_q && s_axi_arvalid) begin
            arready_q <= 1'b0;
            rid_q     <= s_axi_arid;
            rdIdx_q   <= s_axi_araddr[ADDR_WIDTH-1:OFF_W];
            rdata_q   <= mem[s_axi_araddr[ADDR_WIDTH-1:OFF_W]];
            rdMask_q  <= burstMask(s_axi_arburst, s_axi_arlen);
            rdLen_q   <= s_axi_arlen;
            rdCnt_q   <= '0;
            rvalid_q  <= 1'b1;
            rlast_q   <= (s_axi_arlen == 8'd0);
            rdState_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rdState_q <= R_IDLE;
            end else begin
              rdIdx_q <= rdIdx_d;
              rdata_q <= mem[rdIdx_d];
              rdCnt_q <= rdCnt_q + 8'd1;
              rlast_q <= ((rdCnt_q + 8'd1) == rdLen_q);
            end
          end
        end
        default: rdState_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed testbench for axi_ram_slave; inputs change and outputs are sampled on the falling edge.
module tb_axi_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [15:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;

  int          errors = 0;
  int          checks = 0;
  int          rdStall;
  logic [31:0] wrData [16];
  logic [3:0]  wrStrb [16];
  logic [31:0] rdBuf [16];
  logic        rlastBuf [16];
  logic [7:0]  ridBuf [16];

  always #5 clk = ~clk;

  axi_ram_slave dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  // Bus helpers: each is entered and left just after a falling edge.
  task automatic doAw(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
    if (!s_axi_awready) begin checks++; errors++; $display("[TB] FAIL aw_timeout: awready=%0b required 1", s_axi_awready); end
    @(negedge clk);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic doAr(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    if (!s_axi_arready) begin checks++; errors++; $display("[TB] FAIL ar_timeout: arready=%0b required 1", s_axi_arready); end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
  endtask

  task automatic doWBeat(input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
    while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
    if (!s_axi_wready) begin checks++; errors++; $display("[TB] FAIL w_timeout: wready=%0b required 1", s_axi_wready); end
    @(negedge clk);
    s_axi_wvalid = 1'b0;
  endtask

  task automatic doB();
    int n = 0;
    s_axi_bready = 1'b1;
    while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    if (!s_axi_bvalid) begin checks++; errors++; $display("[TB] FAIL b_timeout: bvalid=%0b required 1", s_axi_bvalid); end
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic writeBurst(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
    doAw(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++) doWBeat(wrData[i], wrStrb[i]);
    doB();
  endtask

  task automatic readBurst(input int n);
    int w;
    s_axi_rready = 1'b1;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!s_axi_rvalid && w < 50) begin @(negedge clk); w++; rdStall++; end
      if (!s_axi_rvalid) begin checks++; errors++; $display("[TB] FAIL r_timeout: rvalid=%0b required 1", s_axi_rvalid); break; end
      rdBuf[i] = s_axi_rdata; rlastBuf[i] = s_axi_rlast; ridBuf[i] = s_axi_rid;
      @(negedge clk);
    end
    s_axi_rready = 1'b0;
  endtask

  task automatic readAll(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
    doAr(id, addr, len, burst);
    rdStall = 0;
    readBurst(int'(len) + 1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (s_axi_awready !== 1'b0) begin errors++; $display("[TB] FAIL rst_awready: got %0b expected 0", s_axi_awready); end
    checks++; if (s_axi_arready !== 1'b0) begin errors++; $display("[TB] FAIL rst_arready: got %0b expected 0", s_axi_arready); end
    checks++; if (s_axi_bvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_bvalid: got %0b expected 0", s_axi_bvalid); end
    checks++; if (s_axi_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rvalid: got %0b expected 0", s_axi_rvalid); end
    checks++; if (s_axi_rlast !== 1'b0) begin errors++; $display("[TB] FAIL rst_rlast: got %0b expected 0", s_axi_rlast); end
    checks++; if (s_axi_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata: got %h expected 0", s_axi_rdata); end
    checks++; if (s_axi_bid !== 8'h0 || s_axi_rid !== 8'h0) begin errors++; $display("[TB] FAIL rst_ids: got bid=%h rid=%h expected 0", s_axi_bid, s_axi_rid); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_axi_awready !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_awready: got %0b expected 1", s_axi_awready); end
    checks++; if (s_axi_arready !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_arready: got %0b expected 1", s_axi_arready); end
  endtask

  task automatic test_single();
    doAw(8'h05, 16'h0010, 8'd0, 2'b01);
    doWBeat(32'hDEADBEEF, 4'hF);
    checks++; if (s_axi_bvalid !== 1'b1) begin errors++; $display("[TB] FAIL single_bvalid: got %0b expected 1", s_axi_bvalid); end
    checks++; if (s_axi_bid !== 8'h05) begin errors++; $display("[TB] FAIL single_bid: got %h expected 05", s_axi_bid); end
    checks++; if (s_axi_bresp !== 2'b00) begin errors++; $display("[TB] FAIL single_bresp: got %b expected 00", s_axi_bresp); end
    doB();
    checks++; if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin errors++; $display("[TB] FAIL single_b_done: got bvalid=%0b awready=%0b expected 0 1", s_axi_bvalid, s_axi_awready); end
    doAr(8'h07, 16'h0010, 8'd0, 2'b01);
    checks++; if (s_axi_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL single_rvalid: got %0b expected 1", s_axi_rvalid); end
    readBurst(1);
    checks++; if (rdBuf[0] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_rdata: got %h expected deadbeef", rdBuf[0]); end
    checks++; if (ridBuf[0] !== 8'h07) begin errors++; $display("[TB] FAIL single_rid: got %h expected 07", ridBuf[0]); end
    checks++; if (rlastBuf[0] !== 1'b1) begin errors++; $display("[TB] FAIL single_rlast: got %0b expected 1", rlastBuf[0]); end
    checks++; if (s_axi_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_r_done: got rvalid=%0b expected 0", s_axi_rvalid); end
  endtask

  task automatic test_incr_strb();
    logic [31:0] exp [4];
    exp = '{32'h1, 32'h2, 32'hFFFF0003, 32'h4};
    for (int i = 0; i < 4; i++) begin wrData[i] = 32'hFFFFFFFF; wrStrb[i] = 4'hF; end
    writeBurst(8'h01, 16'h0100, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin wrData[i] = 32'(i + 1); wrStrb[i] = 4'hF; end
    wrStrb[2] = 4'h3;
    writeBurst(8'h01, 16'h0100, 8'd3, 2'b01);
    readAll(8'h02, 16'h0100, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      checks++; if (rdBuf[i] !== exp[i]) begin errors++; $display("[TB] FAIL incr_data[%0d]: got %h expected %h", i, rdBuf[i], exp[i]); end
      checks++; if (rlastBuf[i] !== (i == 3)) begin errors++; $display("[TB] FAIL incr_rlast[%0d]: got %0b expected %0b", i, rlastBuf[i], (i == 3)); end
    end
    checks++; if (rdStall != 0) begin errors++; $display("[TB] FAIL incr_throughput: got %0d idle cycles expected 0", rdStall); end
  endtask

  task automatic test_read_stall();
    int          got = 0;
    logic        phase = 1'b0;
    logic        prevStall = 1'b0;
    logic [31:0] prevData = '0;
    logic        prevLast = 1'b0;
    for (int i = 0; i < 8; i++) begin wrData[i] = 32'hA0 + 32'(i); wrStrb[i] = 4'hF; end
    writeBurst(8'h03, 16'h0200, 8'd7, 2'b01);
    doAr(8'h03, 16'h0200, 8'd7, 2'b01);
    for (int c = 0; c < 100 && got < 8; c++) begin
      if (prevStall) begin
        checks++; if (s_axi_rdata !== prevData || s_axi_rlast !== prevLast) begin errors++; $display("[TB] FAIL stall_stable: got %h/%0b expected %h/%0b", s_axi_rdata, s_axi_rlast, prevData, prevLast); end
      end
      s_axi_rready = phase;
      phase = ~phase;
      if (s_axi_rvalid && s_axi_rready) begin rdBuf[got] = s_axi_rdata; rlastBuf[got] = s_axi_rlast; got++; end
      prevStall = s_axi_rvalid && !s_axi_rready;
      prevData  = s_axi_rdata;
      prevLast  = s_axi_rlast;
      @(negedge clk);
    end
    s_axi_rready = 1'b0;
    checks++; if (got != 8) begin errors++; $display("[TB] FAIL stall_count: got %0d beats expected 8", got); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rdBuf[i] !== 32'hA0 + 32'(i)) begin errors++; $display("[TB] FAIL stall_data[%0d]: got %h expected %h", i, rdBuf[i], 32'hA0 + 32'(i)); end
      checks++; if (rlastBuf[i] !== (i == 7)) begin errors++; $display("[TB] FAIL stall_rlast[%0d]: got %0b expected %0b", i, rlastBuf[i], (i == 7)); end
    end
    checks++; if (s_axi_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL stall_done: got rvalid=%0b expected 0", s_axi_rvalid); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp [6];
`ifdef AXI_RAM_WRAP_EN
    exp = '{32'hB2, 32'hB3, 32'hB0, 32'hB1, 32'hC4, 32'hC5};
`else
    exp = '{32'hC0, 32'hC1, 32'hB0, 32'hB1, 32'hB2, 32'hB3};
`endif
    for (int i = 0; i < 6; i++) begin wrData[i] = 32'hC0 + 32'(i); wrStrb[i] = 4'hF; end
    writeBurst(8'h04, 16'h0100, 8'd5, 2'b01);
    for (int i = 0; i < 4; i++) wrData[i] = 32'hB0 + 32'(i);
    writeBurst(8'h04, 16'h0108, 8'd3, 2'b10);
    readAll(8'h04, 16'h0100, 8'd5, 2'b01);
    for (int i = 0; i < 6; i++) begin
      checks++; if (rdBuf[i] !== exp[i]) begin errors++; $display("[TB] FAIL wrap_mem[%0d]: got %h expected %h", i, rdBuf[i], exp[i]); end
    end
    readAll(8'h04, 16'h0108, 8'd3, 2'b10);
    for (int i = 0; i < 4; i++) begin
      checks++; if (rdBuf[i] !== 32'hB0 + 32'(i)) begin errors++; $display("[TB] FAIL wrap_read[%0d]: got %h expected %h", i, rdBuf[i], 32'hB0 + 32'(i)); end
    end
  endtask

  task automatic test_fixed_modulo();
    wrData[0] = 32'h55; wrStrb[0] = 4'hF;
    writeBurst(8'h06, 16'h0404, 8'd0, 2'b01);
    wrData[0] = 32'h11; wrData[1] = 32'h22; wrData[2] = 32'h33;
    for (int i = 0; i < 3; i++) wrStrb[i] = 4'hF;
    writeBurst(8'h06, 16'h0400, 8'd2, 2'b00);
    readAll(8'h06, 16'h0400, 8'd1, 2'b01);
    checks++; if (rdBuf[0] !== 32'h33 || rdBuf[1] !== 32'h55) begin errors++; $display("[TB] FAIL fixed_write: got %h %h expected 33 55", rdBuf[0], rdBuf[1]); end
    readAll(8'h06, 16'h0404, 8'd1, 2'b00);
    checks++; if (rdBuf[0] !== 32'h55 || rdBuf[1] !== 32'h55) begin errors++; $display("[TB] FAIL fixed_read: got %h %h expected 55 55", rdBuf[0], rdBuf[1]); end
    wrData[0] = 32'h77; wrData[1] = 32'h88;
    writeBurst(8'h06, 16'hFFFC, 8'd1, 2'b01);
    readAll(8'h06, 16'h0000, 8'd0, 2'b01);
    checks++; if (rdBuf[0] !== 32'h88) begin errors++; $display("[TB] FAIL modulo_write: got %h expected 88", rdBuf[0]); end
    readAll(8'h06, 16'hFFFC, 8'd1, 2'b11);
    checks++; if (rdBuf[0] !== 32'h77 || rdBuf[1] !== 32'h88) begin errors++; $display("[TB] FAIL modulo_read: got %h %h expected 77 88", rdBuf[0], rdBuf[1]); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) begin wrData[i] = 32'h0; wrStrb[i] = 4'hF; end
    writeBurst(8'h09, 16'h0500, 8'd3, 2'b01);
    doAw(8'h09, 16'h0500, 8'd3, 2'b01);
    doWBeat(32'h11, 4'hF);
    doWBeat(32'h22, 4'hF);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ready: got awready=%0b wready=%0b expected 0 0", s_axi_awready, s_axi_wready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_axi_awready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_awready: got %0b expected 1", s_axi_awready); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (s_axi_bvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_bvalid: got %0b expected 0", s_axi_bvalid); end
      @(negedge clk);
    end
    readAll(8'h09, 16'h0500, 8'd3, 2'b01);
    checks++; if (rdBuf[0] !== 32'h11 || rdBuf[1] !== 32'h22) begin errors++; $display("[TB] FAIL midrst_kept: got %h %h expected 11 22", rdBuf[0], rdBuf[1]); end
    checks++; if (rdBuf[2] !== 32'h0 || rdBuf[3] !== 32'h0) begin errors++; $display("[TB] FAIL midrst_untouched: got %h %h expected 0 0", rdBuf[2], rdBuf[3]); end
  endtask

  initial begin
    rst = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awburst = '0; s_axi_awvalid = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arburst = '0; s_axi_arvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    rdStall = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_incr_strb();
    test_read_stall();
    test_wrap();
    test_fixed_modulo();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_ram_slave.md
Name:
axi_ram_slave

Overview:
AXI4 responder (slave) backed by single-clock dual-port RAM. It terminates one master port of the AXI interconnect for on-chip buffer storage and bring-up targets. Write and read channels run independently and support INCR/FIXED bursts with ID echo; only full-width beats are supported.

Parameters:
DATA_WIDTH, 32, data bus width in bits (multiple of 8); STRB_WIDTH = DATA_WIDTH/8 as a localparam
ADDR_WIDTH, 16, byte address width; RAM holds 2**(ADDR_WIDTH-log2(STRB_WIDTH)) words
ID_WIDTH, 8, AXI ID width

Ports:
clk  in  1  clock; one clock domain, all logic on its rising edge
rst  in  1  reset, synchronous, active-high
s_axi_awid  in  ID_WIDTH  write ID
s_axi_awaddr  in  ADDR_WIDTH  write start byte address
s_axi_awlen  in  8  beats minus 1
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  STRB_WIDTH  byte enables
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  ID_WIDTH  echoed awid
s_axi_bresp  out  2  always 00 OKAY
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  ID_WIDTH  read ID
s_axi_araddr  in  ADDR_WIDTH  read start byte address
s_axi_arlen  in  8  beats minus 1
s_axi_arburst  in  2  same encoding as awburst
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  echoed arid
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  always 00 OKAY
s_axi_rlast  out  1  final beat of burst
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:
- All outputs registered. Reset values: all valids 0, rlast 0, bid/rid/rdata/bresp/rresp 0. awready and arready are 0 during rst and go to 1 the first cycle after rst deasserts. RAM contents are not reset.
- Word index is addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]. Low address bits are ignored. INCR advances the word index by 1 each beat and wraps modulo RAM size. FIXED holds the index.
- Write FSM states and transitions:
  - W_IDLE: awready=1. AW handshake latches id, addr, len, burst, sets awready=0, goes to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready beat writes the bytes selected by wstrb and increments the beat counter. After len+1 beats, goes to W_RESP. wlast is not a port; beat count alone ends the burst.
  - W_RESP: bvalid=1, bid=latched id. On bready, goes to W_IDLE.
- Read FSM states and transitions:
  - R_IDLE: arready=1. AR handshake latches id, addr, len, burst and reads RAM. rvalid=1 the next cycle with rdata=mem[start]; rlast=(len==0).
  - R_DATA: rdata, rid and rlast hold stable while rvalid&!rready. On each handshake, the next word is loaded the following cycle, giving full throughput. rlast is asserted only on beat len+1. Handshake on that beat: rvalid=0, then R_IDLE.
- Channels are independent. A read and write of the same word in the same cycle returns the old data.
- Reset mid-burst abandons the transaction: no B or R is issued for it. Words already written stay written.

Optional Feature:
AXI_RAM_WRAP_EN: when defined, burst 10 with len in {1,3,7,15} wraps within the aligned (len+1)*STRB_WIDTH byte window; any other len behaves as INCR. When undefined, WRAP is treated as INCR.

Test Plan:
1. Write id 0x5, addr 0x0010, len 0, data 0xDEADBEEF, strb 0xF -> bvalid 1 cycle after W beat, bid 0x5, bresp 00. Read id 0x7 at 0x0010 -> rdata 0xDEADBEEF, rid 0x7, rlast 1, rvalid 1 cycle after AR handshake.
2. INCR len 3 at 0x0100, data 1,2,3,4; beat 2 uses strb 0x3 over prior 0xFFFFFFFF -> readback 1, 2, 0xFFFF0003, 4.
3. INCR len 7 read with rready toggling every cycle -> 8 ordered beats, rdata stable during stalls, rlast only on the 8th.
4. WRAP len 3 at 0x0108 -> with macro: words at 0x108, 0x10C, 0x100, 0x104; without macro: 0x108, 0x10C, 0x110, 0x114.
5. rst pulsed after 2 of 4 write beats -> no bvalid; awready 1 the cycle after rst drops; first 2 words are updated.
